// File: rtl/mat_mult_seq.sv
// Sequential N x N integer matrix multiplier C = A*B over valid/ready streams.
// Operands load row-major, N MAC lanes compute one row of C per N cycles, results drain row-major.
module mat_mult_seq #(
  parameter int N      = 4,
  parameter int W      = 4,
  parameter int SIGNED = 0,
  localparam int OW    = 2*W + $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a_in,
  input  logic [W-1:0]  b_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic          out_last,
  output logic          busy
);
  localparam int NN  = N*N;
  localparam int IW  = $clog2(NN);
  localparam int CW  = $clog2(N);
  localparam bit SGN = (SIGNED != 0);

  typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN} state_t;
  state_t state, state_next;

  logic [IW-1:0]        idx, oidx;
  logic [CW-1:0]        i_cnt, k_cnt;
  logic [W-1:0]         a_mem [NN];
  logic [W-1:0]         b_mem [NN];
  logic signed [OW-1:0] c_mem [NN];
  logic signed [OW-1:0] acc   [N];
  logic signed [OW-1:0] prod  [N];
  logic [IW-1:0]        a_idx, b_base, c_base;
  logic                 accept, fire, k_last, load_done, compute_done, drain_done;

  // Widen an operand to result width so the product and sums never overflow.
  function automatic logic signed [OW-1:0] ext_op(input logic [W-1:0] v);
    return {{(OW-W){SGN & v[W-1]}}, v};
  endfunction

  assign accept       = in_valid & in_ready & (state == LOAD);
  assign fire         = out_valid & out_ready & (state == DRAIN);
  assign k_last       = (k_cnt == CW'(N-1));
  assign load_done    = accept && (idx == IW'(NN-1));
  assign compute_done = (state == COMPUTE) && k_last && (i_cnt == CW'(N-1));
  assign drain_done   = fire && (oidx == IW'(NN-1));
  assign a_idx        = IW'(i_cnt) * IW'(N) + IW'(k_cnt);
  assign b_base       = IW'(k_cnt) * IW'(N);
  assign c_base       = IW'(i_cnt) * IW'(N);
  assign busy         = (state != LOAD);

  always_comb begin
    for (int j = 0; j < N; j++) begin
      prod[j] = ext_op(a_mem[a_idx]) * ext_op(b_mem[b_base + IW'(j)]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LOAD;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (load_done)    state_next = COMPUTE;
      COMPUTE: if (compute_done) state_next = DRAIN;
      DRAIN:   if (drain_done)   state_next = LOAD;
      default:                   state_next = LOAD;
    endcase
  end

  // Control, counters, accumulators and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      idx       <= '0;
      oidx      <= '0;
      i_cnt     <= '0;
      k_cnt     <= '0;
      for (int j = 0; j < N; j++) acc[j] <= '0;
    end else begin
      in_ready  <= (state_next == LOAD);
      out_valid <= (state_next == DRAIN);
      if (accept) idx <= load_done ? '0 : idx + IW'(1);
      if (state == COMPUTE) begin
        k_cnt <= k_last ? '0 : k_cnt + CW'(1);
        if (k_last) i_cnt <= (i_cnt == CW'(N-1)) ? '0 : i_cnt + CW'(1);
        for (int j = 0; j < N; j++) acc[j] <= k_last ? '0 : acc[j] + prod[j];
      end
      // Row 0 of C is complete long before the last row, so it can be presented at once.
      if (compute_done) begin
        out_data <= c_mem[0];
        out_last <= 1'b0;
      end else if (fire) begin
        oidx     <= drain_done ? '0 : oidx + IW'(1);
        out_data <= drain_done ? '0 : c_mem[oidx + IW'(1)];
        out_last <= (oidx == IW'(NN-2));
      end
    end
  end

  // Operand and result storage carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_mem[idx] <= a_in;
      b_mem[idx] <= b_in;
    end
    if ((state == COMPUTE) && k_last) begin
      for (int j = 0; j < N; j++) c_mem[c_base + IW'(j)] <= acc[j] + prod[j];
    end
  end

endmodule

// File: tb/tb_mat_mult_seq.sv
// Directed bench for mat_mult_seq: unsigned and signed 4x4 instances sharing stimulus, plus a 2x2 W=8 instance.
module tb_mat_mult_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, in_valid, out_ready, sel;
  logic [3:0] a_in, b_in;
  logic       in_ready_u, out_valid_u, out_last_u, busy_u;
  logic       in_ready_s, out_valid_s, out_last_s, busy_s;
  logic [9:0] out_data_u, out_data_s;
  logic       in_ready_m, out_valid_m, out_last_m, busy_m;
  logic [9:0] out_data_m;

  logic        in_valid2, out_ready2, in_ready2, out_valid2, out_last2, busy2;
  logic [7:0]  a2, b2;
  logic [16:0] out_data2;

  assign in_ready_m  = sel ? in_ready_s  : in_ready_u;
  assign out_valid_m = sel ? out_valid_s : out_valid_u;
  assign out_last_m  = sel ? out_last_s  : out_last_u;
  assign busy_m      = sel ? busy_s      : busy_u;
  assign out_data_m  = sel ? out_data_s  : out_data_u;

  mat_mult_seq #(.N(4), .W(4), .SIGNED(0)) u_dut_u (
    .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid_u), .out_ready(out_ready),
    .out_data(out_data_u), .out_last(out_last_u), .busy(busy_u));

  mat_mult_seq #(.N(4), .W(4), .SIGNED(1)) u_dut_s (
    .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_data(out_data_s), .out_last(out_last_s), .busy(busy_s));

  mat_mult_seq #(.N(2), .W(8), .SIGNED(0)) u_dut_2 (
    .clk(clk), .reset(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a_in(a2), .b_in(b2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_data(out_data2), .out_last(out_last2), .busy(busy2));

  int n_checks = 0;
  int n_errs   = 0;
  logic [3:0]  A4   [16];
  logic [3:0]  B4   [16];
  logic [9:0]  exp4 [16];
  logic [7:0]  a2v  [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
  logic [7:0]  b2v  [4] = '{8'd5, 8'd6, 8'd7, 8'd8};
  logic [16:0] exp2 [4] = '{17'd19, 17'd22, 17'd43, 17'd50};
  int          pat  [4] = '{1, 0, 0, 1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] gold(input int i, input int j, input bit sgn);
    int s = 0;
    for (int k = 0; k < 4; k++) begin
      int av, bv;
      av = sgn ? int'($signed(A4[4'(i*4+k)])) : int'(A4[4'(i*4+k)]);
      bv = sgn ? int'($signed(B4[4'(k*4+j)])) : int'(B4[4'(k*4+j)]);
      s += av * bv;
    end
    return 10'(s);
  endfunction

  task automatic load4(input string tag, input bit stall);
    for (int n = 0; n < 16; n++) begin
      if (stall && (n % 2 == 1)) begin
        in_valid = 1'b0;
        step();
      end
      a_in = A4[4'(n)];
      b_in = B4[4'(n)];
      in_valid = 1'b1;
      for (int t = 0; t < 20 && !in_ready_m; t++) step();
      if (n == 0 || n == 15) check({tag, "_in_ready"}, 32'(in_ready_m), 32'd1);
      step();
    end
    in_valid = 1'b0;
    check({tag, "_ready_drop"}, 32'(in_ready_m), 32'd0);
    check({tag, "_busy"}, 32'(busy_m), 32'd1);
  endtask

  task automatic wait_result(input string tag);
    int cnt = 0;
    bit rdy = 1'b0;
    while (!out_valid_m && cnt < 100) begin
      if (in_ready_m) rdy = 1'b1;
      step();
      cnt++;
    end
    check({tag, "_latency"}, 32'(cnt), 32'd16);
    check({tag, "_ready_in_compute"}, 32'(rdy), 32'd0);
  endtask

  task automatic drain4(input string tag, input bit bp);
    int beat = 0;
    int cyc = 0;
    bit rdy = 1'b0;
    while (beat < 16 && cyc < 200) begin
      out_ready = bp ? pat[2'(cyc)][0] : 1'b1;
      check({tag, "_data"}, 32'(out_data_m), 32'(exp4[4'(beat)]));
      if (out_ready) begin
        check({tag, "_valid"}, 32'(out_valid_m), 32'd1);
        check({tag, "_last"}, 32'(out_last_m), 32'(beat == 15));
      end
      if (in_ready_m) rdy = 1'b1;
      step();
      cyc++;
      if (out_ready) beat++;
    end
    out_ready = 1'b0;
    check({tag, "_cycles"}, 32'(cyc), bp ? 32'd32 : 32'd16);
    check({tag, "_ready_in_drain"}, 32'(rdy), 32'd0);
    check({tag, "_valid_fall"}, 32'(out_valid_m), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready_m), 32'd1);
    check({tag, "_idle"}, 32'(busy_m), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    int cnt;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0; sel = 1'b0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0;
    repeat (3) step();
    check("rst_in_ready", 32'(in_ready_m), 32'd0);
    check("rst_out_valid", 32'(out_valid_m), 32'd0);
    check("rst_out_last", 32'(out_last_m), 32'd0);
    check("rst_out_data", 32'(out_data_m), 32'd0);
    check("rst_busy", 32'(busy_m), 32'd0);
    rst_n = 1'b1;
    step();
    check("rst_ready_rise", 32'(in_ready_m), 32'd1);

    // Identity times index matrix.
    for (int n = 0; n < 16; n++) begin
      A4[4'(n)] = (n / 4 == n % 4) ? 4'd1 : 4'd0;
      B4[4'(n)] = 4'(n);
      exp4[4'(n)] = 10'(n);
    end
    load4("ident", 1'b0);
    wait_result("ident");
    drain4("ident", 1'b0);

    // All-max unsigned: 4 * 15 * 15 = 900.
    for (int n = 0; n < 16; n++) begin
      A4[4'(n)] = 4'hF; B4[4'(n)] = 4'hF; exp4[4'(n)] = 10'h384;
    end
    load4("max", 1'b0);
    wait_result("max");
    drain4("max", 1'b0);

    // Signed: 4 * (-8) * (-8) = 256, then 4 * 7 * (-8) = -224.
    sel = 1'b1;
    for (int n = 0; n < 16; n++) begin
      A4[4'(n)] = 4'h8; B4[4'(n)] = 4'h8; exp4[4'(n)] = 10'h100;
    end
    load4("sneg", 1'b0);
    wait_result("sneg");
    drain4("sneg", 1'b0);
    for (int n = 0; n < 16; n++) begin
      A4[4'(n)] = 4'h7; B4[4'(n)] = 4'h8; exp4[4'(n)] = 10'h320;
    end
    load4("smix", 1'b0);
    wait_result("smix");
    drain4("smix", 1'b0);

    // Backpressure on both sides with a general unsigned product.
    sel = 1'b0;
    for (int n = 0; n < 16; n++) begin
      A4[4'(n)] = 4'(n * 3 + 1); B4[4'(n)] = 4'(15 - n);
    end
    for (int n = 0; n < 16; n++) exp4[4'(n)] = gold(n / 4, n % 4, 1'b0);
    load4("bp", 1'b1);
    wait_result("bp");
    drain4("bp", 1'b1);

    // Reset five cycles into COMPUTE, then a fresh signed load.
    for (int n = 0; n < 16; n++) begin
      A4[4'(n)] = 4'hF; B4[4'(n)] = 4'h9;
    end
    load4("abort", 1'b0);
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid_m), 32'd0);
    check("abort_busy", 32'(busy_m), 32'd0);
    check("abort_in_ready", 32'(in_ready_m), 32'd0);
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      step();
      if (out_valid_u || out_valid_s) seen = 1'b1;
    end
    check("abort_no_stale_valid", 32'(seen), 32'd0);
    sel = 1'b1;
    for (int n = 0; n < 16; n++) begin
      A4[4'(n)] = 4'(n + 5); B4[4'(n)] = 4'(3 * n + 2);
    end
    for (int n = 0; n < 16; n++) exp4[4'(n)] = gold(n / 4, n % 4, 1'b1);
    load4("fresh", 1'b0);
    wait_result("fresh");
    drain4("fresh", 1'b0);

    // N=2, W=8 instance.
    for (int n = 0; n < 4; n++) begin
      a2 = a2v[2'(n)]; b2 = b2v[2'(n)]; in_valid2 = 1'b1;
      for (int t = 0; t < 20 && !in_ready2; t++) step();
      check("n2_in_ready", 32'(in_ready2), 32'd1);
      step();
    end
    in_valid2 = 1'b0;
    cnt = 0;
    while (!out_valid2 && cnt < 100) begin
      step();
      cnt++;
    end
    check("n2_latency", 32'(cnt), 32'd4);
    out_ready2 = 1'b1;
    for (int n = 0; n < 4; n++) begin
      check("n2_valid", 32'(out_valid2), 32'd1);
      check("n2_data", 32'(out_data2), 32'(exp2[2'(n)]));
      check("n2_last", 32'(out_last2), 32'(n == 3));
      step();
    end
    out_ready2 = 1'b0;
    check("n2_valid_fall", 32'(out_valid2), 32'd0);
    check("n2_ready_back", 32'(in_ready2), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule

// File: doc/mat_mult_seq.md
# mat_mult_seq

Parametrised, sequential N×N integer matrix multiplier computing C = A·B over a valid/ready stream. It is the clocked successor to the team's fixed 4×4 combinational multiplier. It adds a configurable matrix size, configurable element width and signed/unsigned mode. Output width is full precision, so results never overflow. Operands are streamed in, multiplied with N parallel MAC lanes, and results are streamed out row-major. The block sits between an operand source and a result sink, each with its own handshake.

## Interface
- N, default 4: matrix dimension (N ≥ 2).
- W, default 4: operand element width in bits.
- SIGNED, default 0: 0 = unsigned operands/results, 1 = two's-complement.
- OW, derived: 2*W + $clog2(N). Result element width (10 for defaults).
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; low clears all state.
- in_valid  input  1  source has an operand pair.
- in_ready  output  1  block accepts an operand pair.
- a_in  input  W  element A[r][c], streamed row-major.
- b_in  input  W  element B[r][c], same index as a_in.
- out_valid  output  1  out_data holds a valid result.
- out_ready  input  1  sink accepts a result.
- out_data  output  OW  element C[r][c], streamed row-major.
- out_last  output  1  high with C[N-1][N-1].
- busy  output  1  high in COMPUTE or DRAIN.

## Operation
- Storage: A and B register arrays of N*N×W bits each; C array of N*N×OW bits; N accumulators of OW bits.
- States: LOAD → COMPUTE → DRAIN → LOAD.
- LOAD:
  - in_ready=1.
  - Each handshake (in_valid & in_ready) writes a_in to A[idx] and b_in to B[idx]; idx increments 0..N*N-1, with idx = r*N+c.
  - The handshake at idx=N*N-1 moves the block to COMPUTE and drops in_ready on the same edge.
- COMPUTE:
  - in_ready=0. Row counter i and inner counter k start at 0.
  - Each cycle, for all j in parallel: acc[j] ← acc[j] + A[i][k]·B[k][j].
  - When k=N-1: C[i][j] ← acc[j] + A[i][k]·B[k][j], acc[j] ← 0, k ← 0, i ← i+1.
  - After i=N-1, k=N-1 the block moves to DRAIN.
- Arithmetic:
  - SIGNED=0: operands are zero-extended.
  - SIGNED=1: operands are sign-extended to OW before the multiply.
  - Products and sums are computed at OW bits. There is no truncation and no saturation.
- DRAIN:
  - out_valid=1 and out_data=C[oidx]; out_last=1 when oidx=N*N-1.
  - oidx advances on out_valid & out_ready.
  - The last handshake moves the block to LOAD, with in_ready=1 from the next cycle.
  - out_data is held stable while out_valid=1 and out_ready=0.
- in_valid is ignored outside LOAD. out_ready is ignored outside DRAIN.

## Timing
- Reset values (reset low, async): state=LOAD, all counters 0, accumulators 0, in_ready=0, out_valid=0, out_last=0, out_data=0, busy=0.
  - The A/B/C arrays need not be cleared.
- in_ready rises on the first rising clk edge after reset deasserts.
- Input phase takes exactly N*N accepted beats. Source stalls (in_valid=0) insert idle cycles with no state change.
- Latency: let E0 be the edge that accepts the last beat. out_valid rises on edge E0+N*N (16 cycles for N=4) and is registered.
- Drain with out_ready held high takes N*N consecutive cycles. out_valid falls on the edge after the out_last handshake, and in_ready rises on that same edge.
- Throughput with no backpressure: one matrix per 3·N*N cycles. The phases do not overlap.
- All outputs are registered or decoded from registered state only; there is no combinational path from in_valid or out_ready to any output.
- Reset asserted mid-LOAD, mid-COMPUTE or mid-DRAIN aborts immediately to the reset values. Partial inputs and results are discarded, and no out_valid appears afterwards until a full new load completes.
- Asserting in_valid at the same time as reset deasserts is not accepted; the first accept can occur no earlier than the second edge.

## Test plan
- Identity check (N=4, W=4, SIGNED=0): A=I, B[r][c]=r*4+c. Required: out_data sequence 0..15, out_last only on the 16th beat, first out_valid 16 cycles after the last accept.
- All-max unsigned: every element of A and B is 4'hF. Required: all 16 outputs equal 900 (10'h384), with no overflow.
- Signed (SIGNED=1): every element is 4'h8 (-8). Required: all outputs equal 256 (10'h100). Then A = all 4'h7 and B = all 4'h8. Required: all outputs equal -224 (10'h320).
- Backpressure: toggle out_ready 1,0,0,1 during DRAIN and in_valid 1,0 during LOAD. Required: out_data holds across stalls, no beat is dropped or duplicated, in_ready=0 throughout COMPUTE/DRAIN, and results match the golden product.
- Reset mid-COMPUTE: pull reset low 5 cycles into COMPUTE. Required: out_valid=0 and busy=0 immediately. After release, a fresh 16-beat load produces a correct product with no stale data.
- Parameter sweep: N=2 W=8 with A=[[1,2],[3,4]], B=[[5,6],[7,8]]. Required: OW=17, outputs 19,22,43,50, first out_valid 4 cycles after the last accept.
